// File: rtl/code_sequencer.sv
// Program sequencer feeding op codes to the training controller, stepping lines and epochs on controller feedback.
// Optional build macro CODE_SEQ_OVERRUN_ERR_EN: flag a sticky err when a line advance wraps past the last line.
module code_sequencer #(
    parameter int OP_SIZE = 4,
    parameter int DEPTH   = 8,
    parameter int EPOCHS  = 3,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               prog_we,
    input  logic [IDX_W-1:0]   prog_addr,
    input  logic [OP_SIZE-1:0] prog_op,
    input  logic [IDX_W:0]     prog_len,
    input  logic               reset,
    input  logic               code_active,
    input  logic               code_reset,
    output logic [OP_SIZE-1:0] op,
    output logic [31:0]        code_count,
    output logic [31:0]        code_index,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic [31:0]        epoch_left,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t             state, state_nxt;
    logic [OP_SIZE-1:0] mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     len;
    logic [31:0]        cnt;
    logic [31:0]        epochs;
    logic               start_ok;
    logic               addr_ok;
    logic               last_line;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if ((2 ** IDX_W) > DEPTH) begin : g_addr_chk
            assign addr_ok = (32'(prog_addr) < DEPTH_U);
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    assign start_ok  = start && (state != RUN) && (prog_len != '0) && (32'(prog_len) <= DEPTH_U);
    assign last_line = (((IDX_W+1)'(idx)) + (IDX_W+1)'(1)) == len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = RUN;
            RUN:        if (code_reset && (epochs == 32'd1)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            idx    <= '0;
            len    <= '0;
            cnt    <= '0;
            epochs <= '0;
        end else begin
            if ((state != RUN) && prog_we && addr_ok) begin
                mem[prog_addr] <= prog_op;
            end
            if (start_ok) begin
                idx    <= '0;
                cnt    <= '0;
                epochs <= 32'(EPOCHS);
                len    <= prog_len;
            end else if (state == RUN) begin
                if (code_reset) begin
                    idx    <= '0;
                    cnt    <= '0;
                    epochs <= epochs - 32'd1;
                end else if (reset) begin
                    cnt <= '0;
                    if (code_active) begin
                        idx <= last_line ? '0 : idx + 1'b1;
                    end
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

`ifdef CODE_SEQ_OVERRUN_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if ((state == RUN) && !code_reset && reset && code_active && last_line) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs depend only on registered state, never on the feedback inputs.
    assign op         = (state == RUN) ? mem[idx] : '0;
    assign code_count = cnt;
    assign code_index = 32'(idx);
    assign epoch_left = epochs;
    assign enable     = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_code_sequencer.sv
// Scoreboard bench for code_sequencer: a queue-based reference model predicts outputs, a negedge monitor compares.
module tb_code_sequencer;

    localparam int OP_SIZE = 4;
    localparam int DEPTH   = 8;
    localparam int EPOCHS  = 3;
    localparam int IDX_W   = 3;
`ifdef CODE_SEQ_OVERRUN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, prog_we, reset, code_active, code_reset;
    logic [IDX_W-1:0]   prog_addr;
    logic [OP_SIZE-1:0] prog_op;
    logic [IDX_W:0]     prog_len;
    logic [OP_SIZE-1:0] op;
    logic [31:0]        code_count, code_index, epoch_left;
    logic               enable, busy, done, err;

    code_sequencer #(.OP_SIZE(OP_SIZE), .DEPTH(DEPTH), .EPOCHS(EPOCHS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_len(prog_len), .reset(reset), .code_active(code_active),
        .code_reset(code_reset), .op(op), .code_count(code_count), .code_index(code_index),
        .enable(enable), .busy(busy), .done(done), .epoch_left(epoch_left), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_SIZE-1:0] op;
        logic [31:0]        cnt, idx, ep;
        logic               en, done, err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: running flag, finished flag, current line/cycle/epoch as plain numbers.
    bit          m_run, m_done, m_err;
    int unsigned m_idx, m_len, m_ep;
    logic [31:0] m_cnt;
    int          m_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_err = 0;
        m_idx = 0; m_len = 0; m_ep = 0; m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    endfunction

    function automatic void model_step();
        if (!m_run) begin
            if (prog_we && (int'(prog_addr) < DEPTH)) m_mem[prog_addr] = int'(prog_op);
            if (start && (prog_len >= 1) && (int'(prog_len) <= DEPTH)) begin
                m_run = 1; m_done = 0; m_err = 0;
                m_idx = 0; m_cnt = 0; m_ep = EPOCHS; m_len = prog_len;
            end
        end else if (code_reset) begin
            m_idx = 0; m_cnt = 0; m_ep = m_ep - 1;
            if (m_ep == 0) begin m_run = 0; m_done = 1; end
        end else if (reset) begin
            m_cnt = 0;
            if (code_active) begin
                m_idx = m_idx + 1;
                if (m_idx == m_len) begin m_idx = 0; if (ERR_EN) m_err = 1; end
            end
        end else if (m_cnt != 32'hFFFF_FFFF) begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.op   = m_run ? OP_SIZE'(m_mem[m_idx]) : '0;
        e.cnt  = m_cnt;
        e.idx  = m_idx;
        e.ep   = m_ep;
        e.en   = m_run;
        e.done = m_done;
        e.err  = m_err;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("op", op, mon_e.op);
            check("code_count", code_count, mon_e.cnt);
            check("code_index", code_index, mon_e.idx);
            check("epoch_left", epoch_left, mon_e.ep);
            check("enable", enable, mon_e.en);
            check("busy", busy, mon_e.en);
            check("done", done, mon_e.done);
            check("err", err, mon_e.err);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        push_expected();
        #1;
        start = 0; prog_we = 0; reset = 0; code_active = 0; code_reset = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op"}, op, 0);
        check({tag, "_count"}, code_count, 0);
        check({tag, "_index"}, code_index, 0);
        check({tag, "_epoch"}, epoch_left, 0);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        #1 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          line_len;
        int          done_cyc;
        logic [31:0] ep27, ep54;
        int          ops [3];
        ops = '{1, 1, 2};
        done_cyc = 0; ep27 = '0; ep54 = '0;
        rst_n = 0; start = 0; prog_we = 0; reset = 0; code_active = 0; code_reset = 0;
        prog_addr = '0; prog_op = '0; prog_len = '0;
        model_reset();
        #11;
        check_all_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        start = 1; prog_len = 0; step();
        check("len0_enable", enable, 0);
        check("len0_busy", busy, 0);
        start = 1; prog_len = 9; step();
        check("len9_busy", busy, 0);

        for (int i = 0; i < 3; i++) begin
            prog_we = 1; prog_addr = IDX_W'(i); prog_op = OP_SIZE'(ops[i]); step();
        end

        // Controller stand-in: op 1 lines run 12 cycles, op 2 lines run 3, last line ends the epoch.
        prog_len = 3; start = 1; step();
        for (int cyc = 1; cyc <= 200; cyc++) begin
            line_len = (m_mem[m_idx] == 2) ? 3 : 12;
            if (m_cnt == 32'(line_len - 1)) begin
                reset = 1;
                if (m_idx == m_len - 1) code_reset = 1;
                else code_active = 1;
            end
            step();
            if (cyc == 27) ep27 = epoch_left;
            if (cyc == 54) ep54 = epoch_left;
            if (done) begin done_cyc = cyc; break; end
        end
        check("run_epoch_after_27", ep27, 2);
        check("run_epoch_after_54", ep54, 1);
        check("run_done_cycle", 32'(done_cyc), 81);
        check("run_done", done, 1);
        check("run_done_op", op, 0);
        check("run_done_enable", enable, 0);

        start = 1; step();
        code_reset = 1; step();
        code_reset = 1; step();
        check("last_epoch_left", epoch_left, 1);
        code_reset = 1; step();
        check("last_done", done, 1);
        check("last_busy", busy, 0);
        check("last_index", code_index, 0);
        check("last_epoch", epoch_left, 0);

        prog_len = 2; start = 1; step();
        reset = 1; code_active = 1; step();
        check("wrap_index1", code_index, 1);
        reset = 1; code_active = 1; step();
        check("wrap_index0", code_index, 0);
        check("wrap_epoch", epoch_left, 3);
        check("wrap_err", err, 32'(ERR_EN));
        step();
        check("wrap_err_sticky", err, 32'(ERR_EN));

        prog_we = 1; prog_addr = 0; prog_op = 9; step();
        start = 1; prog_len = 3; step();
        check("start_in_run_count", code_count, 3);
        check("start_in_run_index", code_index, 0);
        for (int k = 0; k < 3; k++) begin code_reset = 1; step(); end
        check("we_in_run_done", done, 1);
        start = 1; prog_len = 3; step();
        check("we_in_run_mem0", op, 1);
        check("restart_err_clear", err, 0);

        reset = 1; code_active = 1; step();
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_count", code_count, 5);
        check("pre_rst_index", code_index, 1);
        async_reset();
        prog_we = 1; prog_addr = 0; prog_op = 7; step();
        start = 1; prog_len = 3; step();
        check("post_rst_op", op, 7);

        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 29) == 0);
            prog_we     = ($urandom_range(0, 2) == 0);
            prog_addr   = IDX_W'($urandom_range(0, DEPTH - 1));
            prog_op     = OP_SIZE'($urandom);
            prog_len    = (IDX_W+1)'($urandom_range(0, 9));
            reset       = ($urandom_range(0, 3) == 0);
            code_active = 1'($urandom_range(0, 1));
            code_reset  = ($urandom_range(0, 24) == 0);
            step();
            if (i == 1500) async_reset();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_sequencer.md
# code_sequencer

Program sequencer that sits directly upstream of the training controller. It holds a small program of op codes, one per code line, and presents the current `op`, `code_index` (line) and `code_count` (cycle within line) to the controller. It consumes the controller's `reset`, `code_active` and `code_reset` feedback to step through lines and epochs. It gates the controller with `enable` and owns the epoch counter.

## Interface
Parameters:
- `OP_SIZE`, 4: op code width; must match the controller.
- `DEPTH`, 8: program memory lines.
- `EPOCHS`, 3: epochs run per `start`.
- `IDX_W`, `$clog2(DEPTH)`: program address width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; single-cycle pulse.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  IDX_W  program write address.
- `prog_op`  in  OP_SIZE  op code to write.
- `prog_len`  in  IDX_W+1  number of valid lines; latched at accepted `start`.
- `reset`  in  1  from controller: clear `code_count`.
- `code_active`  in  1  from controller: advance line, qualified by `reset`.
- `code_reset`  in  1  from controller: end of epoch.
- `op`  out  OP_SIZE  current op code to controller.
- `code_count`  out  32  cycles elapsed in current line.
- `code_index`  out  32  current line, zero-extended.
- `enable`  out  1  controller enable.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `epoch_left`  out  32  remaining epochs.
- `err`  out  1  sticky line-overrun flag; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; `code_count`, `code_index`, `epoch_left` = 0. `op`, `enable`, `busy`, `done`, `err` = 0. Program memory cleared to 0.
- `prog_we` writes `mem[prog_addr] <= prog_op` only in IDLE or DONE. It is ignored in RUN. Addresses ≥ DEPTH are ignored.
- In IDLE or DONE, `start` with `prog_len` in 1..DEPTH moves to RUN:
  - `code_index` = 0, `code_count` = 0.
  - `epoch_left` = EPOCHS; length is latched.
  - `done` and `err` are cleared.
- `start` with `prog_len` = 0 or > DEPTH is ignored. `start` in RUN is ignored.
- `op` = `mem[code_index]` (combinational from the registered index) in RUN, and 0 otherwise. `enable` = `busy` = (state == RUN).
- Controller feedback is sampled only in RUN. In IDLE and DONE it is ignored, even though the controller drives `reset` and `code_reset` high while disabled.
- RUN update per cycle, priority order:
  1. `code_reset`: `code_index` = 0, `code_count` = 0, `epoch_left` -= 1. If `epoch_left` was 1, go to DONE.
  2. `reset` & `code_active`: `code_count` = 0. `code_index` += 1, wrapping to 0 when it would equal the latched length; no epoch decrement on wrap.
  3. `reset` & !`code_active`: `code_count` = 0; index unchanged.
  4. Otherwise: `code_count` += 1, saturating at 2^32-1. `code_active` without `reset` is ignored.
- DONE holds `done` = 1, `op` = 0, `enable` = 0 until the next accepted `start`.

## Timing
- `start` sampled high at edge N → RUN from N+1: `enable` = 1, `op` = `mem[0]`, `code_count` = 0.
- Feedback sampled at edge N takes effect on outputs after edge N.
- The combinational path runs `code_index`/`code_count` → controller → feedback → this block's next-state. There is no combinational path from the feedback inputs to `op`, `enable` or the count outputs, so there is no loop.
- Final `code_reset` at edge N → `done` = 1, `enable` = 0 after edge N.
- `rst_n` low mid-run forces all reset values immediately, without waiting for `clk`.

## Configuration
- `CODE_SEQ_OVERRUN_ERR_EN`:
  - Defined: a line wrap under rule 2 (advance from the last line) sets `err` = 1, sticky until the next accepted `start` or `rst_n`. The index still wraps to 0.
  - Undefined: `err` is tied to 0 and the wrap is silent.

## Test plan
- Full run with the real controller (size 3). Load ops [1,1,2], `prog_len` = 3, EPOCHS = 3, pulse `start`.
  - Lines 0 and 1 last 12 cycles each; line 2 lasts 3 cycles.
  - `epoch_left` reads 2 after cycle 27 and 1 after cycle 54.
  - `done` = 1 after cycle 81, with `op` = 0 and `enable` = 0.
- Force `code_reset` = 1 with `epoch_left` = 1 → next cycle DONE, `code_index` = 0, `epoch_left` = 0, `busy` = 0.
- `prog_len` = 2, index 1, drive `reset` = `code_active` = 1 → `code_index` = 0, `epoch_left` unchanged. `err` = 1 with the macro defined, 0 without.
- Pull `rst_n` low at `code_count` = 5, line 1 → outputs zero immediately, state IDLE. After release, `start` → `op` = `mem[0]`.
- `prog_we` to addr 0 during RUN → `mem[0]` unchanged after DONE. `start` while RUN → `code_count` unaffected.
- `start` with `prog_len` = 0 → stays IDLE, `enable` = 0, `busy` = 0.
